// File: rtl/mem_access_stage.sv
`default_nettype none
// mem_access_stage: MEM pipeline stage with a wait-stated internal data memory,
// an upstream stall and the MEM/WB output register.
module mem_access_stage #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] StoreData_in,
  input  logic [4:0]  RtRd_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        LoadSigned_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  output logic        Stall_out,
  output logic        Valid_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  RtRd_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        AddrErr_out
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [0:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept_wait, complete, mem_we;

  logic [31:0] req_addr, req_data;
  logic [4:0]  req_rtrd;
  logic        req_rd, req_wr, req_signed, req_regwrite, req_memtoreg;
  logic [1:0]  req_size;

  logic [31:0] sel_addr, sel_data;
  logic [4:0]  sel_rtrd;
  logic        sel_rd, sel_wr, sel_signed, sel_regwrite, sel_memtoreg, sel_mis;
  logic [1:0]  sel_size;
  logic        in_mis;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] rd_word, wr_word, ld_data;
  logic [15:0] lane16;
  logic [7:0]  lane8;

  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] size);
    case (size)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  assign in_mis = (MemRead_in | MemWrite_in) & misaligned(ALUResult_in[1:0], MemSize_in);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept_wait) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_INIT;
      end
      BUSY: if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall drops in the completing cycle so upstream advances exactly once.
  always_comb begin
    accept_wait = 1'b0;
    complete    = 1'b0;
    Stall_out   = 1'b0;
    case (state)
      IDLE: begin
        accept_wait = Valid_in & (MemRead_in | MemWrite_in) & ~in_mis & HAS_WAIT;
        complete    = Valid_in & ~accept_wait;
        Stall_out   = accept_wait;
      end
      BUSY: begin
        complete  = (cnt == 4'd0);
        Stall_out = (cnt != 4'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      req_addr     <= 32'd0;
      req_data     <= 32'd0;
      req_rtrd     <= 5'd0;
      req_rd       <= 1'b0;
      req_wr       <= 1'b0;
      req_size     <= 2'b00;
      req_signed   <= 1'b0;
      req_regwrite <= 1'b0;
      req_memtoreg <= 1'b0;
    end else if (accept_wait) begin
      req_addr     <= ALUResult_in;
      req_data     <= StoreData_in;
      req_rtrd     <= RtRd_in;
      req_rd       <= MemRead_in;
      req_wr       <= MemWrite_in;
      req_size     <= MemSize_in;
      req_signed   <= LoadSigned_in;
      req_regwrite <= RegWrite_in;
      req_memtoreg <= MemToReg_in;
    end
  end

  always_comb begin
    if (state == BUSY) begin
      sel_addr     = req_addr;
      sel_data     = req_data;
      sel_rtrd     = req_rtrd;
      sel_rd       = req_rd;
      sel_wr       = req_wr;
      sel_size     = req_size;
      sel_signed   = req_signed;
      sel_regwrite = req_regwrite;
      sel_memtoreg = req_memtoreg;
    end else begin
      sel_addr     = ALUResult_in;
      sel_data     = StoreData_in;
      sel_rtrd     = RtRd_in;
      sel_rd       = MemRead_in;
      sel_wr       = MemWrite_in;
      sel_size     = MemSize_in;
      sel_signed   = LoadSigned_in;
      sel_regwrite = RegWrite_in;
      sel_memtoreg = MemToReg_in;
    end
  end

  assign sel_mis = (sel_rd | sel_wr) & misaligned(sel_addr[1:0], sel_size);
  assign idx     = sel_addr[AW+1:2];
  assign rd_word = mem[idx];
  assign lane16  = rd_word[{sel_addr[1], 4'b0000} +: 16];
  assign lane8   = rd_word[{sel_addr[1:0], 3'b000} +: 8];
  assign mem_we  = complete & sel_wr & ~sel_mis;

  always_comb begin
    wr_word = rd_word;
    case (sel_size)
      2'b01:   wr_word[{sel_addr[1], 4'b0000} +: 16] = sel_data[15:0];
      2'b10:   wr_word[{sel_addr[1:0], 3'b000} +: 8] = sel_data[7:0];
      default: wr_word = sel_data;
    endcase
  end

  always_comb begin
    case (sel_size)
      2'b01:   ld_data = sel_signed ? {{16{lane16[15]}}, lane16} : {16'd0, lane16};
      2'b10:   ld_data = sel_signed ? {{24{lane8[7]}}, lane8} : {24'd0, lane8};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Valid_out     <= 1'b0;
      ReadData_out  <= 32'd0;
      ALUResult_out <= 32'd0;
      RtRd_out      <= 5'd0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      AddrErr_out   <= 1'b0;
    end else if (complete) begin
      Valid_out     <= 1'b1;
      ReadData_out  <= (sel_rd & ~sel_wr & ~sel_mis) ? ld_data : 32'd0;
      ALUResult_out <= sel_addr;
      RtRd_out      <= sel_rtrd;
      RegWrite_out  <= sel_regwrite & ~sel_mis;
      MemToReg_out  <= sel_memtoreg;
      AddrErr_out   <= sel_mis;
    end else begin
      Valid_out     <= 1'b0;
      ReadData_out  <= 32'd0;
      ALUResult_out <= 32'd0;
      RtRd_out      <= 5'd0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      AddrErr_out   <= 1'b0;
    end
  end

endmodule
`default_nettype wire
